// File: rtl/sram_bw_init_pkg.sv
// sram_pkg: shared definitions for the sram_bw_init memory slice.
//   BYTE_W        width of one byte lane
//   sram_state_t  clear-sequencer states
//   even_parity   parity bit that makes (byte, bit) carry an even number of ones
package sram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_DONE  = 1'b1
    } sram_state_t;

    function automatic logic even_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_bw_init_if.sv
// sram_bw_init_if: access port of the sram_bw_init memory.
//   cen     access enable (read, optionally write)
//   wen     per-byte write enables, bit i covers D[8i+7:8i]
//   A       word address
//   D       write data
//   Q       registered read data
//   rvalid  one-cycle pulse when Q carries a new read result
//   ready   clear sequence finished, accesses accepted
//   perr    parity error on the current Q
// Modports: master drives the request, slave is the memory.
interface sram_bw_init_if #(
    parameter int DW = 32,
    parameter int AW = 13
);
    localparam int NB = DW / sram_pkg::BYTE_W;

    logic          cen;
    logic [NB-1:0] wen;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;
    logic          rvalid;
    logic          ready;
    logic          perr;

    modport master (
        output cen, wen, A, D,
        input  Q, rvalid, ready, perr
    );

    modport slave (
        input  cen, wen, A, D,
        output Q, rvalid, ready, perr
    );

endinterface

// File: rtl/sram_bw_init_clear_seq.sv
// sram_clear_seq: post-reset sweep that zeroes every word of the memory.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_we      write strobe for the zero fill (high for every CLEAR cycle)
//   clr_addr    word being cleared this cycle
//   ready       sweep finished; stays high until the next reset
// The last word is written on the DEPTH-th edge after reset release, and the
// same edge enters DONE, so ready rises exactly DEPTH cycles after release.
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int IW    = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          clr_we,
    output logic [IW-1:0] clr_addr,
    output logic          ready
);

    localparam logic [0:0]    ST_CLEAR = S_CLEAR;
    localparam logic [0:0]    ST_DONE  = S_DONE;
    localparam logic [IW-1:0] LAST     = IW'(DEPTH - 1);

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_we   = 1'b0;
        clr_addr = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (ptr_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ready = (state_q == ST_DONE);

endmodule

// File: rtl/sram_bw_init.sv
// sram_bw_init: single-port synchronous SRAM with per-byte write enables,
// read-first semantics, a post-reset clear sweep and a read-valid qualifier.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         sram_bw_init_if.slave (cen, wen, A, D -> Q, rvalid, ready, perr)
// Parameters: DW data width (multiple of 8), AW address width, DEPTH words
// (<= 2**AW; addresses >= DEPTH never write and read back as 0).
// Build option: define SRAM_PARITY_EN to store one even-parity bit per byte
// and flag mismatches on perr; otherwise perr is constant 0.
module sram_bw_init
    import sram_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 13,
    parameter int DEPTH = 1 << AW
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_bw_init_if.slave  bus
);

    localparam int NB = DW / BYTE_W;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Clear sequencer
    logic          ready;
    logic          clr_we;
    logic [IW-1:0] clr_addr;

    sram_clear_seq #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // Port decode
    logic          in_range;
    logic [IW-1:0] acc_addr;

    assign in_range = (32'(bus.A) < 32'(DEPTH));
    assign acc_addr = bus.A[IW-1:0];

    // Storage write port: the sequencer owns it until ready, the bus after.
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [NB-1:0] wr_be;
    logic [DW-1:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_addr;
        wr_be   = '1;
        wr_data = '0;
        if (!ready) begin
            wr_en = clr_we;
        end else begin
            wr_en   = bus.cen & in_range & (|bus.wen);
            wr_addr = acc_addr;
            wr_be   = bus.wen;
            wr_data = bus.D;
        end
    end

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rd_word = mem_q[acc_addr];

    // Parity check of the word being read (pre-write contents)
    logic rd_perr;

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] wr_par;
    logic [NB-1:0] rd_par;

    always_comb begin
        wr_par = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            wr_par[i] = even_parity(wr_data[i*BYTE_W +: BYTE_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    par_q[wr_addr][i] <= wr_par[i];
                end
            end
        end
    end

    assign rd_par = par_q[acc_addr];

    always_comb begin
        rd_perr = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            rd_perr = rd_perr | (even_parity(rd_word[i*BYTE_W +: BYTE_W]) ^ rd_par[i]);
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    // Read output registers; mem_q is sampled before this edge's write lands,
    // which gives read-first behaviour on a same-address write.
    logic [DW-1:0] q_q, q_d;
    logic          rvalid_q, rvalid_d;
    logic          perr_q, perr_d;

    always_comb begin
        q_d      = q_q;
        rvalid_d = 1'b0;
        perr_d   = perr_q;
        if (ready && bus.cen) begin
            rvalid_d = 1'b1;
            if (in_range) begin
                q_d    = rd_word;
                perr_d = rd_perr;
            end else begin
                q_d    = '0;
                perr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= '0;
            rvalid_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            q_q      <= q_d;
            rvalid_q <= rvalid_d;
            perr_q   <= perr_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.rvalid = rvalid_q;
    assign bus.perr   = perr_q;
    assign bus.ready  = ready;

endmodule

// File: tb/tb_sram_bw_init.sv
// Bench for sram_bw_init with DW=32, AW=4, DEPTH=16. A behavioural model of
// the memory is compared against the DUT outputs on every falling edge, and
// directed scenarios add literal expectations.
module tb_sram_bw_init;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

`ifdef SRAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sram_bw_init_if #(.DW(DW), .AW(AW)) bus ();

    sram_bw_init #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic [31:0] m_mem [DEPTH];
    logic [3:0]  m_bad [DEPTH];
    logic [31:0] m_q      = '0;
    logic        m_rvalid = 1'b0;
    logic        m_ready  = 1'b0;
    logic        m_perr   = 1'b0;
    int          m_cnt    = 0;
    int          ma;
    logic [31:0] mmask;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q      = '0;
            m_rvalid = 1'b0;
            m_ready  = 1'b0;
            m_perr   = 1'b0;
            m_cnt    = 0;
        end else if (!m_ready) begin
            m_rvalid = 1'b0;
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                for (int w = 0; w < DEPTH; w++) begin
                    m_mem[w] = '0;
                    m_bad[w] = '0;
                end
            end
        end else if (bus.cen) begin
            m_rvalid = 1'b1;
            ma = int'(bus.A);
            if (ma < DEPTH) begin
                m_q    = m_mem[ma];
                m_perr = PAR_EN && (m_bad[ma] != 4'h0);
                for (int l = 0; l < 4; l++) mmask[8*l +: 8] = {8{bus.wen[l]}};
                m_mem[ma] = (m_mem[ma] & ~mmask) | (bus.D & mmask);
                m_bad[ma] = m_bad[ma] & ~bus.wen;
            end else begin
                m_q    = '0;
                m_perr = 1'b0;
            end
        end else begin
            m_rvalid = 1'b0;
        end
    end

    // Per-cycle compare
    always @(negedge clk) begin
        check("ready",  {31'b0, bus.ready},  {31'b0, m_ready});
        check("rvalid", {31'b0, bus.rvalid}, {31'b0, m_rvalid});
        check("Q",      bus.Q,               m_q);
        check("perr",   {31'b0, bus.perr},   {31'b0, m_perr});
    end

    task automatic step(input logic c, input logic [3:0] w, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        #1;
        bus.cen = c;
        bus.wen = w;
        bus.A   = a;
        bus.D   = d;
    endtask

    // Called just after a falling edge: releases reset and counts rising
    // edges until ready is seen, bounded.
    task automatic release_and_count(input string nm);
        int got;
        got = 0;
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                got = i;
                break;
            end
        end
        check(nm, got, 16);
    endtask

    initial begin
        bus.cen = 1'b0;
        bus.wen = '0;
        bus.A   = '0;
        bus.D   = '0;
        repeat (2) @(negedge clk);
        check("reset_Q",      bus.Q, 32'h0);
        check("reset_ready",  {31'b0, bus.ready}, 32'h0);
        check("reset_rvalid", {31'b0, bus.rvalid}, 32'h0);

        // 1: clear latency, then every word reads zero
        release_and_count("t1_ready_latency");
        for (int a = 0; a < DEPTH; a++) step(1'b1, 4'h0, 4'(a), 32'h0);
        step(1'b0, 4'h0, 4'h0, 32'h0);
        check("t1_Q_last",      bus.Q, 32'h0);
        check("t1_rvalid_last", {31'b0, bus.rvalid}, 32'h1);
        check("t1_perr_last",   {31'b0, bus.perr}, 32'h0);
        step(1'b0, 4'h0, 4'h0, 32'h0);
        check("t1_rvalid_idle", {31'b0, bus.rvalid}, 32'h0);

        // 2: byte-lane merge
        step(1'b1, 4'hF, 4'd3, 32'hDDCCBBAA);
        step(1'b1, 4'h5, 4'd3, 32'h11223344);
        step(1'b1, 4'h0, 4'd3, 32'h0);
        check("t2_rf_prev", bus.Q, 32'hDDCCBBAA);
        step(1'b0, 4'h0, 4'h0, 32'h0);
        check("t2_merge", bus.Q, 32'hDD22BB44);

        // 3: read-first on same-address write
        step(1'b1, 4'hF, 4'd5, 32'h12345678);
        step(1'b1, 4'hF, 4'd5, 32'hFFFFFFFF);
        step(1'b1, 4'h0, 4'd5, 32'h0);
        check("t3_read_first", bus.Q, 32'h12345678);
        step(1'b0, 4'h0, 4'h0, 32'h0);
        check("t3_new_value", bus.Q, 32'hFFFFFFFF);
        check("t3_Q_hold", bus.Q, 32'hFFFFFFFF);

        // 6: parity
        step(1'b1, 4'hF, 4'd7, 32'hA5A50F0F);
        step(1'b1, 4'hF, 4'd6, 32'h0F0F0F0F);
        step(1'b0, 4'h0, 4'h0, 32'h0);
`ifdef SRAM_PARITY_EN
        dut.mem_q[7][9] = ~dut.mem_q[7][9];
        m_mem[7][9]     = ~m_mem[7][9];
        m_bad[7][1]     = 1'b1;
`endif
        step(1'b1, 4'h0, 4'd7, 32'h0);
        step(1'b0, 4'h0, 4'h0, 32'h0);
`ifdef SRAM_PARITY_EN
        check("t6_perr_bad", {31'b0, bus.perr}, 32'h1);
        check("t6_Q7",       bus.Q, 32'hA5A50D0F);
`else
        check("t6_perr_bad", {31'b0, bus.perr}, 32'h0);
        check("t6_Q7",       bus.Q, 32'hA5A50F0F);
`endif
        step(1'b1, 4'h0, 4'd6, 32'h0);
        step(1'b0, 4'h0, 4'h0, 32'h0);
        check("t6_perr_clean", {31'b0, bus.perr}, 32'h0);
        check("t6_Q6",         bus.Q, 32'h0F0F0F0F);

        // 4 + 5: reset mid-clear with an access held on the bus
        @(negedge clk);
        #1 rst_n = 1'b0;
        bus.cen = 1'b1;
        bus.wen = 4'hF;
        bus.A   = 4'd2;
        bus.D   = 32'h1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t5_rvalid_clear", {31'b0, bus.rvalid}, 32'h0);
        check("t4_ready_mid",    {31'b0, bus.ready}, 32'h0);
        check("t5_Q_clear",      bus.Q, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        release_and_count("t4_ready_latency");
        bus.cen = 1'b0;
        bus.wen = 4'h0;
        step(1'b1, 4'h0, 4'd2, 32'h0);
        step(1'b1, 4'h0, 4'd3, 32'h0);
        check("t5_A2_zero", bus.Q, 32'h0);
        step(1'b1, 4'h0, 4'd5, 32'h0);
        check("t4_A3_zero", bus.Q, 32'h0);
        step(1'b0, 4'h0, 4'h0, 32'h0);
        check("t4_A5_zero", bus.Q, 32'h0);
        step(1'b0, 4'h0, 4'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
